bsg_link_fwd_rev_mux: RTL and testbench



---
 rtl/bsg_link_mux_pkg.sv | 27 ++
 rtl/bsg_fifo_1r1w_small.sv | 56 +++++
 rtl/bsg_link_mux_credit_counter.sv | 46 ++++
 rtl/bsg_link_fwd_rev_mux.sv | 163 ++++++++++++++++
 tb/tb_bsg_link_fwd_rev_mux.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_link_mux_pkg.sv
// Shared definitions for the bsg_link fwd/rev mux: channel tags, merged-word field
// offsets and the merged word struct macro.
`ifndef BSG_LINK_MUX_PKG_SV
`define BSG_LINK_MUX_PKG_SV

`define BSG_LINK_MUX_DECLARE_WORD_S(width_mp) \
    typedef struct packed { \
        logic                payload_v; \
        logic                tag; \
        logic [1:0]          credit_ret; \
        logic [width_mp-1:0] data; \
    } bsg_link_mux_word_s;

package bsg_link_mux_pkg;

    localparam logic fwd_tag_gp = 1'b1;
    localparam logic rev_tag_gp = 1'b0;

    // Header field positions measured from the top of the data field (bit = width_p + offset).
    localparam int credit_ret_offset_gp = 0;
    localparam int tag_offset_gp        = 2;
    localparam int payload_v_offset_gp  = 3;
    localparam int mux_hdr_width_gp     = 4;

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready input and valid/yumi output; the head
// entry is visible the cycle after it is written.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 4
)(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p+1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    wr, rd;

    assign ready_o = (count_q != cnt_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign wr      = v_i & ready_o;
    assign rd      = yumi_i & v_o;

    always_comb begin
        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + cnt_width_lp'(1);
        end else if (rd && !wr) begin
            count_d = count_q - cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (wr) wptr_q <= (wptr_q == ptr_width_lp'(els_p-1)) ? '0 : wptr_q + ptr_width_lp'(1);
            if (rd) rptr_q <= (rptr_q == ptr_width_lp'(els_p-1)) ? '0 : rptr_q + ptr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_link_mux_credit_counter.sv
// Up/down credit counter with a reset value; overflow past max_p and underflow are
// flagged by simulation assertions.
module bsg_link_mux_credit_counter #(
    parameter int width_p = 3,
    parameter int init_p  = 0,
    parameter int max_p   = 4
)(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    // Simultaneous up and down cancel.
    always_comb begin
        count_d = count_q;
        if (up_i && !down_i) begin
            count_d = count_q + width_p'(1);
        end else if (down_i && !up_i) begin
            count_d = count_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= width_p'(init_p);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(up_i && !down_i && count_q == width_p'(max_p)));
            assert (!(down_i && !up_i && count_q == '0));
        end
    end
`endif

endmodule

// File: rtl/bsg_link_fwd_rev_mux.sv
// Merges the fwd/rev ready-and channels onto one link word with independent per-channel
// credits. Define BSG_LINK_FWD_REV_MUX_REV_PRIORITY_EN for strict rev priority.
module bsg_link_fwd_rev_mux
    import bsg_link_mux_pkg::*;
#(
    parameter  int width_p         = 32,
    parameter  int els_p           = 4,
    localparam int credit_width_lp = $clog2(els_p+1),
    localparam int mux_width_lp    = width_p + mux_hdr_width_gp
)(
    input  logic                    bsg_link_clk_i,
    input  logic                    bsg_link_reset_n_i,

    input  logic [1:0]              ch_v_i,
    input  logic [2*width_p-1:0]    ch_data_i,
    output logic [1:0]              ch_ready_and_o,

    output logic                    mux_v_o,
    output logic [mux_width_lp-1:0] mux_data_o,
    input  logic                    mux_ready_and_i,

    input  logic                    mux_v_i,
    input  logic [mux_width_lp-1:0] mux_data_i,
    output logic                    mux_ready_and_o,

    output logic [1:0]              ch_v_o,
    output logic [2*width_p-1:0]    ch_data_o,
    input  logic [1:0]              ch_ready_and_i
);

    `BSG_LINK_MUX_DECLARE_WORD_S(width_p)

    logic                       link_up_q;
    logic [1:0]                 eligible, grant, pend_nz, send, pop, rx_wr, rx_cr;
    logic [1:0]                 fifo_ready, fifo_v, rx_credit_ret;
    logic                       tx_hs, rx_hs, rx_payload_v, rx_tag;
    logic [credit_width_lp-1:0] tx_credit   [2];
    logic [credit_width_lp-1:0] pend_credit [2];
    bsg_link_mux_word_s         tx_word;

    // Holds every output low until the first edge after reset release.
    always_ff @(posedge bsg_link_clk_i or negedge bsg_link_reset_n_i) begin
        if (!bsg_link_reset_n_i) begin
            link_up_q <= 1'b0;
        end else begin
            link_up_q <= 1'b1;
        end
    end

`ifdef BSG_LINK_FWD_REV_MUX_REV_PRIORITY_EN
    always_comb begin
        grant = 2'b00;
        if (eligible[rev_tag_gp]) begin
            grant[rev_tag_gp] = 1'b1;
        end else begin
            grant[fwd_tag_gp] = eligible[fwd_tag_gp];
        end
    end
`else
    logic rr_last_q, rr_last_d;

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant             = 2'b00;
            grant[~rr_last_q] = 1'b1;
        end
        rr_last_d = rr_last_q;
        if (tx_hs && (|grant)) begin
            rr_last_d = grant[fwd_tag_gp];
        end
    end

    always_ff @(posedge bsg_link_clk_i or negedge bsg_link_reset_n_i) begin
        if (!bsg_link_reset_n_i) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_comb begin
        tx_word            = '0;
        tx_word.credit_ret = pend_nz;
        if (|grant) begin
            tx_word.payload_v = 1'b1;
            tx_word.tag       = grant[fwd_tag_gp] ? fwd_tag_gp : rev_tag_gp;
            tx_word.data      = grant[fwd_tag_gp] ? ch_data_i[width_p +: width_p]
                                                  : ch_data_i[0 +: width_p];
        end
    end

    assign mux_v_o         = (|eligible) | (|pend_nz);
    assign mux_data_o      = tx_word;
    assign tx_hs           = mux_v_o & mux_ready_and_i;
    assign send            = grant & {2{tx_hs}};
    assign ch_ready_and_o  = grant & {2{mux_ready_and_i}};

    assign mux_ready_and_o = link_up_q;
    assign rx_hs           = mux_v_i & mux_ready_and_o;
    assign rx_payload_v    = mux_data_i[width_p + payload_v_offset_gp];
    assign rx_tag          = mux_data_i[width_p + tag_offset_gp];
    assign rx_credit_ret   = mux_data_i[width_p + credit_ret_offset_gp +: 2];
    assign ch_v_o          = fifo_v;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        assign eligible[c] = link_up_q & ch_v_i[c] & (tx_credit[c] != '0);
        assign pend_nz[c]  = (pend_credit[c] != '0);
        assign rx_wr[c]    = rx_hs & rx_payload_v & (rx_tag == 1'(c));
        assign rx_cr[c]    = rx_hs & rx_credit_ret[c];
        assign pop[c]      = fifo_v[c] & ch_ready_and_i[c];

        bsg_link_mux_credit_counter #(
            .width_p (credit_width_lp),
            .init_p  (els_p),
            .max_p   (els_p)
        ) tx_cnt (
            .clk_i     (bsg_link_clk_i),
            .reset_n_i (bsg_link_reset_n_i),
            .up_i      (rx_cr[c]),
            .down_i    (send[c]),
            .count_o   (tx_credit[c])
        );

        // Credits owed to the far end: one per pop, returned one per outgoing word.
        bsg_link_mux_credit_counter #(
            .width_p (credit_width_lp),
            .init_p  (0),
            .max_p   (els_p)
        ) pend_cnt (
            .clk_i     (bsg_link_clk_i),
            .reset_n_i (bsg_link_reset_n_i),
            .up_i      (pop[c]),
            .down_i    (tx_hs & pend_nz[c]),
            .count_o   (pend_credit[c])
        );

        bsg_fifo_1r1w_small #(
            .width_p (width_p),
            .els_p   (els_p)
        ) rx_fifo (
            .clk_i     (bsg_link_clk_i),
            .reset_n_i (bsg_link_reset_n_i),
            .v_i       (rx_wr[c]),
            .data_i    (mux_data_i[width_p-1:0]),
            .ready_o   (fifo_ready[c]),
            .v_o       (fifo_v[c]),
            .data_o    (ch_data_o[c*width_p +: width_p]),
            .yumi_i    (pop[c])
        );
    end

`ifndef SYNTHESIS
    always_ff @(posedge bsg_link_clk_i) begin
        if (bsg_link_reset_n_i) begin
            assert (!(rx_wr[0] && !fifo_ready[0]));
            assert (!(rx_wr[1] && !fifo_ready[1]));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_link_fwd_rev_mux.sv
// Directed bench for bsg_link_fwd_rev_mux: reset, loopback streaming, credit stall and
// return, same-cycle credit events and mid-burst reset.
module tb_bsg_link_fwd_rev_mux;

    localparam int W  = 32;
    localparam int E  = 4;
    localparam int MW = W + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ch_v_i;
    logic [2*W-1:0] ch_data_i;
    logic [1:0]    ch_ready_and_o;
    logic          mux_v_o;
    logic [MW-1:0] mux_data_o;
    logic          mux_ready_and_i;
    logic          mux_v_i;
    logic [MW-1:0] mux_data_i;
    logic          mux_ready_and_o;
    logic [1:0]    ch_v_o;
    logic [2*W-1:0] ch_data_o;
    logic [1:0]    ch_ready_and_i;

    logic          lb_en;
    logic          tb_mux_v;
    logic [MW-1:0] tb_mux_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Loopback only delivers a word when the transmit side actually hands it off.
    assign mux_v_i    = lb_en ? (mux_v_o & mux_ready_and_i) : tb_mux_v;
    assign mux_data_i = lb_en ? mux_data_o : tb_mux_data;

    bsg_link_fwd_rev_mux #(.width_p(W), .els_p(E)) dut (
        .bsg_link_clk_i     (clk),
        .bsg_link_reset_n_i (rst_n),
        .ch_v_i             (ch_v_i),
        .ch_data_i          (ch_data_i),
        .ch_ready_and_o     (ch_ready_and_o),
        .mux_v_o            (mux_v_o),
        .mux_data_o         (mux_data_o),
        .mux_ready_and_i    (mux_ready_and_i),
        .mux_v_i            (mux_v_i),
        .mux_data_i         (mux_data_i),
        .mux_ready_and_o    (mux_ready_and_o),
        .ch_v_o             (ch_v_o),
        .ch_data_o          (ch_data_o),
        .ch_ready_and_i     (ch_ready_and_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_v_i   = 2'b00;
        lb_en    = 1'b0;
        tb_mux_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] fi, ri;
        int          nf, nr;
        logic        exp_tag;

        rst_n           = 1'b0;
        ch_v_i          = 2'b11;
        ch_data_i       = {32'hdead_beef, 32'hcafe_f00d};
        mux_ready_and_i = 1'b1;
        ch_ready_and_i  = 2'b11;
        lb_en           = 1'b0;
        tb_mux_v        = 1'b1;
        tb_mux_data     = {4'b1000, 32'h1234};

        // Held in reset: all outputs low even with inputs active.
        #2;
        check("rst_mux_v", mux_v_o, 0);
        check("rst_mux_data", mux_data_o, 0);
        check("rst_ch_ready", ch_ready_and_o, 0);
        check("rst_mux_ready", mux_ready_and_o, 0);
        check("rst_ch_v", ch_v_o, 0);

        ch_v_i   = 2'b00;
        tb_mux_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("up_mux_ready", mux_ready_and_o, 1);
        check("up_tx_credit0", dut.tx_credit[0], E);
        check("up_tx_credit1", dut.tx_credit[1], E);
        check("up_pend0", dut.pend_credit[0], 0);
        check("up_ch_v", ch_v_o, 0);

`ifndef BSG_LINK_FWD_REV_MUX_REV_PRIORITY_EN
        // Loopback, both channels streaming, sinks always ready: strict alternation.
        lb_en          = 1'b1;
        ch_ready_and_i = 2'b11;
        ch_v_i         = 2'b11;
        fi = 0; ri = 0;
        for (int k = 0; k < 8; k++) begin
            ch_data_i = {32'h100 + fi, 32'h200 + ri};
            #1;
            exp_tag = (k % 2 == 0);
            check("lb_grant", ch_ready_and_o, exp_tag ? 2'b10 : 2'b01);
            check("lb_hdr", mux_data_o[MW-1 -: 2], {1'b1, exp_tag});
            check("lb_data", mux_data_o[W-1:0], exp_tag ? 32'h100 + k/2 : 32'h200 + k/2);
            check("lb_credit_ret", mux_data_o[W +: 2], (k < 2) ? 2'b00 : (exp_tag ? 2'b10 : 2'b01));
            if (k > 0) begin
                check("lb_rx_v", ch_v_o, exp_tag ? 2'b01 : 2'b10);
                if (exp_tag) check("lb_rx_rev", ch_data_o[W-1:0], 32'h200 + (k-1)/2);
                else         check("lb_rx_fwd", ch_data_o[2*W-1:W], 32'h100 + (k-1)/2);
            end
            fi += 32'(ch_ready_and_o[1]);
            ri += 32'(ch_ready_and_o[0]);
            step();
        end
        ch_v_i = 2'b00;
        for (int k = 0; k < 6; k++) step();
        check("lb_drain_v", mux_v_o, 0);
        check("lb_drain_cr0", dut.tx_credit[0], E);
        check("lb_drain_cr1", dut.tx_credit[1], E);
        check("lb_drain_pend1", dut.pend_credit[1], 0);

        // Rev sink blocked: 4 rev words, then rev stalls while fwd keeps going.
        do_reset();
        lb_en          = 1'b1;
        ch_ready_and_i = 2'b10;
        ch_v_i         = 2'b11;
        fi = 0; ri = 0; nf = 0; nr = 0;
        for (int k = 0; k < 14; k++) begin
            ch_data_i = {32'h100 + fi, 32'h200 + ri};
            #1;
            nf += int'(ch_ready_and_o[1]);
            nr += int'(ch_ready_and_o[0]);
            fi += 32'(ch_ready_and_o[1]);
            ri += 32'(ch_ready_and_o[0]);
            step();
        end
        ch_data_i = {32'h100 + fi, 32'h200 + ri};
        #1;
        check("stall_rev_sent", nr, 4);
        check("stall_fwd_sent", nf, 10);
        check("stall_cr0", dut.tx_credit[0], 0);
        check("stall_grant", ch_ready_and_o, 2'b10);
        check("stall_rx_rev_v", ch_v_o[0], 1);

        ch_v_i = 2'b00;
        for (int k = 0; k < 6; k++) step();
        check("drain_cr1", dut.tx_credit[1], E);
        check("drain_ch_v", ch_v_o, 2'b01);
        check("drain_mux_v", mux_v_o, 0);

        // Release rev sink with the link stalled so the pending credits pile up.
        mux_ready_and_i = 1'b0;
        ch_ready_and_i  = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("release_rev_data", ch_data_o[W-1:0], 32'h200 + j);
            step();
        end
        check("release_pend0", dut.pend_credit[0], E);
        check("release_ch_v", ch_v_o, 2'b00);
        check("release_mux_v", mux_v_o, 1);

        mux_ready_and_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("credit_only_v", mux_v_o, 1);
            check("credit_only_word", mux_data_o, {4'b0001, 32'h0});
            step();
        end
        #1;
        check("credit_done_v", mux_v_o, 0);
        check("credit_done_cr0", dut.tx_credit[0], E);
        check("credit_done_ch_v", ch_v_o, 2'b00);
`else
        // Strict rev priority: rev until its credits run out, then fwd.
        do_reset();
        ch_ready_and_i  = 2'b00;
        mux_ready_and_i = 1'b1;
        ch_v_i          = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("prio_grant", ch_ready_and_o, (k < 4) ? 2'b01 : 2'b10);
            step();
        end
`endif

        // Send on fwd in the same cycle as a fwd credit return.
        do_reset();
        ch_ready_and_i  = 2'b00;
        mux_ready_and_i = 1'b1;
        ch_v_i          = 2'b10;
        ch_data_i       = {32'h0000_0aaa, 32'h0};
        step();
        step();
        check("same_pre_cr1", dut.tx_credit[1], 2);
        tb_mux_v    = 1'b1;
        tb_mux_data = {4'b0010, 32'h0};
        #1;
        check("same_grant", ch_ready_and_o, 2'b10);
        step();
        check("same_cr1", dut.tx_credit[1], 2);
        ch_v_i = 2'b00;
        step();
        check("ret_only_cr1", dut.tx_credit[1], 3);
        check("ret_only_no_write", ch_v_o, 2'b00);
        tb_mux_data = {4'b1000, 32'h0000_abcd};
        step();
        tb_mux_v = 1'b0;
        #1;
        check("rx_rev_v", ch_v_o, 2'b01);
        check("rx_rev_data", ch_data_o[W-1:0], 32'h0000_abcd);
        check("rx_rev_no_cr", dut.tx_credit[1], 3);
        ch_ready_and_i = 2'b01;
        step();
        check("rx_rev_popped", ch_v_o, 2'b00);
        check("rx_rev_pend0", dut.pend_credit[0], 1);

        // Asynchronous reset in the middle of a loopback burst.
        lb_en          = 1'b1;
        ch_ready_and_i = 2'b11;
        ch_v_i         = 2'b11;
        ch_data_i      = {32'h0000_0111, 32'h0000_0222};
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mux_v", mux_v_o, 0);
        check("mid_rst_mux_data", mux_data_o, 0);
        check("mid_rst_ch_ready", ch_ready_and_o, 0);
        check("mid_rst_mux_ready", mux_ready_and_o, 0);
        check("mid_rst_ch_v", ch_v_o, 0);
        ch_v_i = 2'b00;
        lb_en  = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_cr0", dut.tx_credit[0], E);
        check("post_rst_cr1", dut.tx_credit[1], E);
        check("post_rst_pend0", dut.pend_credit[0], 0);
        check("post_rst_ch_v", ch_v_o, 0);
        check("post_rst_mux_ready", mux_ready_and_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
